// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
//
// Packs field-level instruction descriptions into 16-bit instruction words
// and streams them to an instruction memory (or instruction register) through
// a valid/ready write port with an incrementing word address.
//
// Word layout produced (matches the datapath instruction decoder):
//   opcode[15:13] op[12:11] rn[10:8] rd[7:5] shift[4:3] rm[2:0]
//   imm5 occupies [4:0], imm8 occupies [7:0]; unused bits are zero.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      one-cycle pulse: clear address/error, begin accepting
//   in_valid   instruction fields valid
//   in_ready   encoder accepts fields this cycle
//   fmt        0=REG, 1=IMM8, 2=IMM5, 3=reserved (rejected)
//   opcode, op, rn, rd, rm, shift, imm   instruction fields
//   out_valid  mem_din/mem_addr valid
//   out_ready  sink accepts the word
//   mem_addr   word address (AW bits)
//   mem_din    encoded instruction word
//   full       LAST_ADDR has been written; accepts resume only after start
//   err        sticky: an instruction was rejected since start/reset
//
// Optional build macro INSTR_ENC_CHECKSUM_EN adds output checksum[15:0],
// the running XOR of every transferred word (cleared by reset and start).
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset; waiting for start
// S_ACCEPT | in_ready=1; encode and check incoming fields
// S_WRITE  | out_valid=1; word and address held until out_ready
// S_FULL   | LAST_ADDR written; waiting for start
//
module instruction_encoder #(
    parameter int AW        = 8,
    parameter int LAST_ADDR = (1 << AW) - 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    fmt,
    input  logic [2:0]    opcode,
    input  logic [1:0]    op,
    input  logic [2:0]    rn,
    input  logic [2:0]    rd,
    input  logic [2:0]    rm,
    input  logic [1:0]    shift,
    input  logic [15:0]   imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic          full,
    output logic          err
`ifdef INSTR_ENC_CHECKSUM_EN
    ,
    output logic [15:0]   checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_FULL   = 2'd3
    } state_t;

    localparam logic [1:0]    FMT_REG  = 2'd0;
    localparam logic [1:0]    FMT_IMM8 = 2'd1;
    localparam logic [1:0]    FMT_IMM5 = 2'd2;
    localparam logic [AW-1:0] LAST     = AW'(LAST_ADDR);

    state_t state;
    state_t state_next;

    logic [15:0] packed_word;
    logic        reject;
    logic        accept;
    logic        xfer;
    logic        at_last;

    // Field packing and range check. An immediate is accepted only if its
    // upper bits are a pure sign extension of the field's top bit, so the
    // decoder's sign extension reproduces the original value exactly.
    always_comb begin
        packed_word = 16'h0000;
        reject      = 1'b0;
        case (fmt)
            FMT_REG: begin
                packed_word = {opcode, op, rn, rd, shift, rm};
            end
            FMT_IMM8: begin
                packed_word = {opcode, op, rn, imm[7:0]};
                reject      = !((&imm[15:7]) || !(|imm[15:7]));
            end
            FMT_IMM5: begin
                packed_word = {opcode, op, rn, rd, imm[4:0]};
                reject      = !((&imm[15:4]) || !(|imm[15:4]));
            end
            default: begin
                reject = 1'b1;
            end
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign xfer    = out_valid & out_ready;
    assign at_last = (mem_addr == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        full       = 1'b0;

        case (state)
            S_IDLE: begin
            end
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid && !reject) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = at_last ? S_FULL : S_ACCEPT;
                end
            end
            S_FULL: begin
                full = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // start overrides everything, including a pending word in S_WRITE
        if (start) begin
            state_next = S_ACCEPT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_din  <= 16'h0000;
            err      <= 1'b0;
        end else if (start) begin
            mem_addr <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                if (reject) begin
                    err <= 1'b1;
                end else begin
                    mem_din <= packed_word;
                end
            end
            // Address stays on LAST when the final word lands; no wrap.
            if (xfer && !at_last) begin
                mem_addr <= mem_addr + 1'b1;
            end
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= 16'h0000;
        end else if (start) begin
            checksum <= 16'h0000;
        end else if (xfer) begin
            checksum <= checksum ^ mem_din;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

    logic        clk;
    logic        reset;
    logic        reset2;
    logic        start;
    logic        start2;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  fmt;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic [15:0] imm;

    logic        in_ready;
    logic        out_valid;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic        full;
    logic        err;

    logic        in_ready2;
    logic        out_valid2;
    logic [1:0]  mem_addr2;
    logic [15:0] mem_din2;
    logic        full2;
    logic        err2;

`ifdef INSTR_ENC_CHECKSUM_EN
    logic [15:0] checksum;
    logic [15:0] checksum2;
`endif

    int errors = 0;
    int checks = 0;

    instruction_encoder #(.AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .op        (op),
        .rn        (rn),
        .rd        (rd),
        .rm        (rm),
        .shift     (shift),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .full      (full),
        .err       (err)
`ifdef INSTR_ENC_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    instruction_encoder #(.AW(2)) dut2 (
        .clk       (clk),
        .reset     (reset2),
        .start     (start2),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .fmt       (fmt),
        .opcode    (opcode),
        .op        (op),
        .rn        (rn),
        .rd        (rd),
        .rm        (rm),
        .shift     (shift),
        .imm       (imm),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .mem_addr  (mem_addr2),
        .mem_din   (mem_din2),
        .full      (full2),
        .err       (err2)
`ifdef INSTR_ENC_CHECKSUM_EN
        ,
        .checksum  (checksum2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fields(input logic [1:0] f, input logic [2:0] oc, input logic [1:0] o,
                          input logic [2:0] n, input logic [2:0] d, input logic [1:0] s,
                          input logic [2:0] m, input logic [15:0] i);
        fmt = f; opcode = oc; op = o; rn = n; rd = d; shift = s; rm = m; imm = i;
    endtask

    // Called at a falling edge; presents fields for exactly one rising edge.
    task automatic send();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1; start = 1'b0; start2 = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        fields(2'd0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 3'd0, 16'h0000);

        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
`ifdef INSTR_ENC_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif

        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        // in_valid while idle is ignored
        fields(2'd0, 3'b101, 2'b00, 3'd1, 3'd2, 2'b01, 3'd0, 16'h0000);
        send();
        chk("idle_ignore_out_valid", out_valid, 0);

        pulse_start();
        chk("start_in_ready", in_ready, 1);
        chk("start_mem_addr", mem_addr, 0);

        // REG word, one-cycle latency, then address increments
        out_ready = 1'b1;
        send();
        chk("reg_out_valid", out_valid, 1);
        chk("reg_mem_din", mem_din, 16'hA148);
        chk("reg_mem_addr", mem_addr, 0);
        chk("reg_in_ready", in_ready, 0);
        @(negedge clk);
        chk("reg_done_out_valid", out_valid, 0);
        chk("reg_done_in_ready", in_ready, 1);
        chk("reg_done_mem_addr", mem_addr, 1);
`ifdef INSTR_ENC_CHECKSUM_EN
        chk("cks_after_a148", checksum, 16'hA148);
`endif

        // IMM8 -5 with sink stalled for 5 cycles; extra in_valid must be ignored
        out_ready = 1'b0;
        fields(2'd1, 3'b110, 2'b10, 3'd3, 3'd0, 2'd0, 3'd0, 16'hFFFB);
        send();
        chk("imm8_out_valid", out_valid, 1);
        chk("imm8_mem_din", mem_din, 16'hD3FB);
        chk("imm8_mem_addr", mem_addr, 1);
        fields(2'd0, 3'b111, 2'b11, 3'd7, 3'd7, 2'b11, 3'd7, 16'h0000);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_mem_din", mem_din, 16'hD3FB);
            chk("stall_mem_addr", mem_addr, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_done_mem_addr", mem_addr, 2);
        chk("stall_done_out_valid", out_valid, 0);
        chk("stall_done_in_ready", in_ready, 1);
`ifdef INSTR_ENC_CHECKSUM_EN
        chk("cks_after_d3fb", checksum, 16'h72B3);
`endif

        // IMM8 out-of-range 200 rejected
        fields(2'd1, 3'b110, 2'b10, 3'd3, 3'd0, 2'd0, 3'd0, 16'h00C8);
        send();
        chk("imm8_200_out_valid", out_valid, 0);
        chk("imm8_200_err", err, 1);
        chk("imm8_200_in_ready", in_ready, 1);
        chk("imm8_200_mem_addr", mem_addr, 2);

        // IMM8 boundaries
        imm = 16'h007F;
        send();
        chk("imm8_127_out_valid", out_valid, 1);
        chk("imm8_127_mem_din", mem_din, 16'hD37F);
        @(negedge clk);
        chk("imm8_127_mem_addr", mem_addr, 3);
        chk("err_sticky", err, 1);
        imm = 16'hFF7F;
        send();
        chk("imm8_m129_out_valid", out_valid, 0);
        imm = 16'hFF80;
        send();
        chk("imm8_m128_out_valid", out_valid, 1);
        chk("imm8_m128_mem_din", mem_din, 16'hD380);
        @(negedge clk);
        chk("imm8_m128_mem_addr", mem_addr, 4);

        pulse_start();
        chk("restart_err", err, 0);
        chk("restart_mem_addr", mem_addr, 0);
`ifdef INSTR_ENC_CHECKSUM_EN
        chk("restart_checksum", checksum, 0);
`endif

        // IMM5
        fields(2'd2, 3'b011, 2'b00, 3'd1, 3'd2, 2'd0, 3'd0, 16'hFFFF);
        send();
        chk("imm5_m1_out_valid", out_valid, 1);
        chk("imm5_m1_mem_din", mem_din, 16'h615F);
        @(negedge clk);
        chk("imm5_m1_mem_addr", mem_addr, 1);
        imm = 16'h0010;
        send();
        chk("imm5_16_out_valid", out_valid, 0);
        chk("imm5_16_err", err, 1);
        imm = 16'hFFF0;
        send();
        chk("imm5_m16_mem_din", mem_din, 16'h6150);
        chk("imm5_m16_out_valid", out_valid, 1);
        @(negedge clk);
        imm = 16'h000F;
        send();
        chk("imm5_15_mem_din", mem_din, 16'h614F);
        @(negedge clk);
        chk("imm5_15_mem_addr", mem_addr, 3);

        // Reserved format
        pulse_start();
        fields(2'd3, 3'b101, 2'b00, 3'd1, 3'd2, 2'b01, 3'd0, 16'h0000);
        send();
        chk("fmt3_err", err, 1);
        chk("fmt3_out_valid", out_valid, 0);
        chk("fmt3_in_ready", in_ready, 1);

        // start during WRITE drops the pending word
        out_ready = 1'b0;
        fields(2'd0, 3'b101, 2'b00, 3'd1, 3'd2, 2'b01, 3'd0, 16'h0000);
        send();
        chk("midw_out_valid", out_valid, 1);
        pulse_start();
        chk("midw_drop_out_valid", out_valid, 0);
        chk("midw_in_ready", in_ready, 1);
        chk("midw_mem_addr", mem_addr, 0);
        chk("midw_err", err, 0);

        // Async reset while in WRITE
        out_ready = 1'b1;
        send();
        @(negedge clk);
        fields(2'd1, 3'b110, 2'b10, 3'd3, 3'd0, 2'd0, 3'd0, 16'h00C8);
        send();
        out_ready = 1'b0;
        imm = 16'hFFFB;
        send();
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_mem_addr", mem_addr, 1);
        chk("pre_rst_err", err, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_din", mem_din, 0);
        chk("arst_full", full, 0);
        chk("arst_err", err, 0);
`ifdef INSTR_ENC_CHECKSUM_EN
        chk("arst_checksum", checksum, 0);
`endif

        // AW=2 instance: fill to LAST_ADDR=3
        @(negedge clk);
        reset2 = 1'b0;
        @(negedge clk);
        pulse_start2();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fields(2'd0, 3'b101, 2'b00, 3'd1, 3'd2, 2'b01, 3'(k), 16'h0000);
            send();
            chk("aw2_out_valid", out_valid2, 1);
            chk("aw2_mem_addr", mem_addr2, k);
            chk("aw2_mem_din", mem_din2, 16'hA148 | k);
            @(negedge clk);
        end
        chk("aw2_full", full2, 1);
        chk("aw2_full_in_ready", in_ready2, 0);
        chk("aw2_full_out_valid", out_valid2, 0);
        chk("aw2_full_mem_addr", mem_addr2, 3);
        send();
        chk("aw2_full_ignore", out_valid2, 0);
        chk("aw2_full_hold", full2, 1);
        pulse_start2();
        chk("aw2_restart_full", full2, 0);
        chk("aw2_restart_mem_addr", mem_addr2, 0);
        chk("aw2_restart_in_ready", in_ready2, 1);
        send();
        chk("aw2_restart_out_valid", out_valid2, 1);
        chk("aw2_restart_addr0", mem_addr2, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
